decoder_stream: RTL and testbench

- Parametrised successor to the team's fixed 7-bit combinational decoder project.
- Takes binary codes over a valid/ready stream and decodes each into an NUM_OUT-bit pattern, selectable per transaction: one-hot, thermometer, active-low one-hot, or sticky accumulate.
- Results are buffered in a 2-entry output queue. Out-of-range codes are flagged and counted.
- Sits between the io_in pad capture logic and downstream per-line enables.

---
 rtl/decoder_stream.sv | 112 +++++++++++
 tb/tb_decoder_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream.sv
// Streaming code decoder: one-hot / thermometer / inverted one-hot / sticky patterns,
// delivered through a 2-entry output queue with out-of-range flagging and error count.
module decoder_stream #(
   parameter int IN_W    = 3,
   parameter int NUM_OUT = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_code,
   input  logic [1:0]         in_mode,
   input  logic               clr_sticky,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_data,
   output logic               out_err,
   output logic [CNT_W-1:0]   err_cnt
);

   localparam logic [IN_W:0] LP_NUM_OUT = (IN_W+1)'(NUM_OUT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [1:0]         r_cnt;
   logic [NUM_OUT-1:0] r_data [2];
   logic               r_err  [2];
   logic [NUM_OUT-1:0] r_sticky;
   logic [CNT_W-1:0]   r_err_cnt;

   logic               w_push;
   logic               w_pop;
   logic               w_inrange;
   logic               w_wr_idx;
   logic [NUM_OUT-1:0] w_onehot;
   logic [NUM_OUT-1:0] w_therm;
   logic [NUM_OUT-1:0] w_sticky_base;
   logic [NUM_OUT-1:0] w_sticky_acc;
   logic [NUM_OUT-1:0] w_sticky_next;
   logic [NUM_OUT-1:0] w_entry_data;

   // Handshake status derives only from the occupancy register, never from out_ready.
   assign in_ready  = rst_n && (r_cnt != 2'd2);
   assign out_valid = rst_n && (r_cnt != 2'd0);
   assign out_data  = out_valid ? r_data[0] : '0;
   assign out_err   = out_valid && r_err[0];
   assign err_cnt   = r_err_cnt;

   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_inrange = ({1'b0, in_code} < LP_NUM_OUT);
   assign w_wr_idx  = (r_cnt == 2'd1) && !w_pop;

   always_comb begin
      w_onehot = '0;
      w_therm  = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         w_onehot[i] = (IN_W'(i) == in_code);
         w_therm[i]  = (IN_W'(i) <= in_code);
      end
   end

   assign w_sticky_base = clr_sticky ? '0 : r_sticky;
   assign w_sticky_acc  = w_sticky_base | w_onehot;
   assign w_sticky_next = (w_push && w_inrange && (in_mode == 2'b11)) ? w_sticky_acc
                                                                      : w_sticky_base;

   always_comb begin
      w_entry_data = '0;
      if (w_inrange) begin
         case (in_mode)
            2'b00:   w_entry_data = w_onehot;
            2'b01:   w_entry_data = w_therm;
            2'b10:   w_entry_data = ~w_onehot;
            default: w_entry_data = w_sticky_acc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= 2'd0;
         r_sticky  <= '0;
         r_err_cnt <= '0;
      end else begin
         r_sticky <= w_sticky_next;
         if (w_push && !w_inrange)
            r_err_cnt <= sat_inc(r_err_cnt);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: it is only observed through out_valid.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_data[0] <= r_data[1];
         r_err[0]  <= r_err[1];
      end
      if (w_push) begin
         r_data[w_wr_idx] <= w_entry_data;
         r_err[w_wr_idx]  <= !w_inrange;
      end
   end

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: two instances (8 lines, and 6 lines with a 2-bit counter)
// compared each cycle against a queue-based model, plus directed literal expectations.
module tb_decoder_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       a_vin, a_clr, a_ordy;
   logic [2:0] a_code;
   logic [1:0] a_mode;
   logic       a_irdy, a_ovld, a_oerr;
   logic [7:0] a_data;
   logic [7:0] a_cnt;

   logic       b_vin, b_clr, b_ordy;
   logic [2:0] b_code;
   logic [1:0] b_mode;
   logic       b_irdy, b_ovld, b_oerr;
   logic [5:0] b_data;
   logic [1:0] b_cnt;

   decoder_stream #(.IN_W(3), .NUM_OUT(8), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_vin), .in_ready(a_irdy), .in_code(a_code),
      .in_mode(a_mode), .clr_sticky(a_clr), .out_valid(a_ovld), .out_ready(a_ordy),
      .out_data(a_data), .out_err(a_oerr), .err_cnt(a_cnt));

   decoder_stream #(.IN_W(3), .NUM_OUT(6), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_vin), .in_ready(b_irdy), .in_code(b_code),
      .in_mode(b_mode), .clr_sticky(b_clr), .out_valid(b_ovld), .out_ready(b_ordy),
      .out_data(b_data), .out_err(b_oerr), .err_cnt(b_cnt));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: each queue entry is {err, data}.
   logic [8:0] mq0[$];
   logic [8:0] mq1[$];
   logic [7:0] m_sticky [2];
   int         m_ecnt   [2];

   function automatic int q_size(input int d);
      return (d == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [8:0] q_head(input int d);
      if (d == 0) return mq0[0];
      return mq1[0];
   endfunction

   logic       m_vin, m_clr, m_ordy, m_err, m_push, m_pop;
   logic [2:0] m_code;
   logic [1:0] m_mode;
   logic [7:0] m_mask, m_val, m_base;
   int         m_no, m_cmax, m_k, m_sz;

   initial begin
      m_sticky[0] = '0; m_sticky[1] = '0;
      m_ecnt[0] = 0;    m_ecnt[1] = 0;
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         m_vin  = d ? b_vin  : a_vin;
         m_clr  = d ? b_clr  : a_clr;
         m_ordy = d ? b_ordy : a_ordy;
         m_code = d ? b_code : a_code;
         m_mode = d ? b_mode : a_mode;
         m_no   = d ? 6 : 8;
         m_cmax = d ? 3 : 255;
         m_mask = 8'((1 << m_no) - 1);
         if (!rst_n) begin
            if (d == 0) mq0.delete(); else mq1.delete();
            m_sticky[d] = '0;
            m_ecnt[d]   = 0;
         end else begin
            m_sz   = q_size(d);
            m_pop  = (m_sz > 0) && m_ordy;
            m_push = m_vin && (m_sz < 2);
            m_base = m_clr ? 8'h00 : m_sticky[d];
            m_k    = int'(m_code);
            m_val  = '0;
            m_err  = 1'b0;
            if (m_push) begin
               if (m_k < m_no) begin
                  case (m_mode)
                     2'b00:   m_val = 8'(1 << m_k);
                     2'b01:   m_val = 8'((1 << (m_k + 1)) - 1);
                     2'b10:   m_val = ~8'(1 << m_k) & m_mask;
                     default: begin
                        m_val  = m_base | 8'(1 << m_k);
                        m_base = m_val;
                     end
                  endcase
               end else begin
                  m_err = 1'b1;
                  if (m_ecnt[d] < m_cmax) m_ecnt[d]++;
               end
            end
            m_sticky[d] = m_base;
            if (m_pop) begin
               if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            end
            if (m_push) begin
               if (d == 0) mq0.push_back({m_err, m_val}); else mq1.push_back({m_err, m_val});
            end
         end
      end
   end

   logic [8:0] c_head;
   logic       c_v, c_r;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         c_v    = rst_n && (q_size(d) > 0);
         c_r    = rst_n && (q_size(d) < 2);
         c_head = c_v ? q_head(d) : 9'h000;
         if (d == 0) begin
            chk("A.out_valid", 32'(a_ovld), 32'(c_v));
            chk("A.in_ready",  32'(a_irdy), 32'(c_r));
            chk("A.out_data",  32'(a_data), 32'(c_head[7:0]));
            chk("A.out_err",   32'(a_oerr), 32'(c_head[8]));
            chk("A.err_cnt",   32'(a_cnt),  32'(m_ecnt[0]));
         end else begin
            chk("B.out_valid", 32'(b_ovld), 32'(c_v));
            chk("B.in_ready",  32'(b_irdy), 32'(c_r));
            chk("B.out_data",  32'(b_data), 32'(c_head[7:0]));
            chk("B.out_err",   32'(b_oerr), 32'(c_head[8]));
            chk("B.err_cnt",   32'(b_cnt),  32'(m_ecnt[1]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int b_exp_cnt [4] = '{1, 2, 3, 3};
   int b_codes   [4] = '{6, 7, 6, 7};

   initial begin
      rst_n = 1'b0;
      a_vin = 0; a_clr = 0; a_ordy = 0; a_code = 0; a_mode = 0;
      b_vin = 0; b_clr = 0; b_ordy = 0; b_code = 0; b_mode = 0;
      repeat (3) tick();
      chk("reset out_valid", 32'(a_ovld), 32'd0);
      chk("reset in_ready",  32'(a_irdy), 32'd0);
      chk("reset out_data",  32'(a_data), 32'd0);

      rst_n = 1'b1; a_ordy = 1; a_vin = 1; a_code = 3'd5; a_mode = 2'b00;
      tick();
      chk("onehot5 valid", 32'(a_ovld), 32'd1);
      chk("onehot5 data",  32'(a_data), 32'h20);
      chk("onehot5 err",   32'(a_oerr), 32'd0);
      chk("release in_ready", 32'(a_irdy), 32'd1);
      a_vin = 0;
      tick();
      chk("onehot5 drained", 32'(a_ovld), 32'd0);

      a_vin = 1; a_code = 3'd3; a_mode = 2'b01;
      tick();
      chk("therm3 data", 32'(a_data), 32'h0F);
      a_mode = 2'b10;
      tick();
      chk("inv3 data", 32'(a_data), 32'hF7);
      a_vin = 0;
      tick();

      a_vin = 1; a_mode = 2'b11; a_code = 3'd1;
      tick(); chk("sticky1", 32'(a_data), 32'h02);
      a_code = 3'd4;
      tick(); chk("sticky4", 32'(a_data), 32'h12);
      a_code = 3'd6;
      tick(); chk("sticky6", 32'(a_data), 32'h52);
      a_code = 3'd0; a_clr = 1;
      tick(); chk("sticky clr0", 32'(a_data), 32'h01);
      a_clr = 0; a_vin = 0;
      tick();

      a_ordy = 0; a_vin = 1; a_mode = 2'b00; a_code = 3'd2;
      tick();
      chk("bp first data",  32'(a_data), 32'h04);
      chk("bp first ready", 32'(a_irdy), 32'd1);
      a_code = 3'd7;
      tick();
      chk("bp full ready", 32'(a_irdy), 32'd0);
      chk("bp head held",  32'(a_data), 32'h04);
      a_code = 3'd1;
      tick();
      chk("bp still full", 32'(a_irdy), 32'd0);
      chk("bp head stable", 32'(a_data), 32'h04);
      a_vin = 0; a_ordy = 1;
      tick();
      chk("bp second data", 32'(a_data), 32'h80);
      chk("bp ready back",  32'(a_irdy), 32'd1);
      tick();
      chk("bp third dropped", 32'(a_ovld), 32'd0);

      b_ordy = 1; b_vin = 1;
      for (int i = 0; i < 4; i++) begin
         b_code = 3'(b_codes[i]);
         b_mode = 2'(i);
         tick();
         chk("err data",  32'(b_data), 32'd0);
         chk("err flag",  32'(b_oerr), 32'd1);
         chk("err count", 32'(b_cnt),  32'(b_exp_cnt[i]));
      end
      b_vin = 0;
      tick();

      a_ordy = 0; a_vin = 1; a_code = 3'd1; a_mode = 2'b11;
      tick();
      a_code = 3'd2; a_mode = 2'b00;
      tick();
      chk("mid two queued", 32'(a_irdy), 32'd0);
      a_vin = 0; rst_n = 0;
      #1;
      chk("mid reset valid", 32'(a_ovld), 32'd0);
      tick();
      rst_n = 1;
      #1;
      chk("post reset valid", 32'(a_ovld), 32'd0);
      chk("post reset errcnt", 32'(b_cnt), 32'd0);
      a_vin = 1; a_code = 3'd0; a_mode = 2'b11; a_ordy = 1;
      tick();
      chk("post reset sticky", 32'(a_data), 32'h01);
      a_vin = 0;
      tick();

      repeat (4000) begin
         @(posedge clk);
         #1;
         rst_n  = ($urandom_range(0, 299) != 0);
         a_vin  = ($urandom_range(0, 9) < 7);
         a_code = 3'($urandom_range(0, 7));
         a_mode = 2'($urandom_range(0, 3));
         a_clr  = ($urandom_range(0, 7) == 0);
         a_ordy = ($urandom_range(0, 9) < 6);
         b_vin  = ($urandom_range(0, 9) < 7);
         b_code = 3'($urandom_range(0, 7));
         b_mode = 2'($urandom_range(0, 3));
         b_clr  = ($urandom_range(0, 7) == 0);
         b_ordy = ($urandom_range(0, 9) < 6);
      end
      rst_n = 1; a_vin = 0; b_vin = 0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
